// File: rtl/pal_pkg.sv
// Shared encodings and default levels for the PAL composite generator.
package pal_pkg;

    typedef enum logic [1:0] {
        MODE_BLACK = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_RAMP  = 2'd2,
        MODE_CHECK = 2'd3
    } mode_e;

    localparam int SYNC_LVL      = 0;
    localparam int DEF_BLANK_LVL = 77;
    localparam int DEF_WHITE_LVL = 255;
    localparam int BAR_MAX       = 7;

endpackage

// File: rtl/pal_pattern.sv
// Combinational test-pattern level for one active pixel, clamped to white.
module pal_pattern
    import pal_pkg::*;
#(
    parameter int DAC_W      = 8,
    parameter int BLANK_LVL  = DEF_BLANK_LVL,
    parameter int WHITE_LVL  = DEF_WHITE_LVL,
    parameter int BAR_STEP   = 25,
    parameter int RAMP_SHIFT = 4,
    parameter int CHK_SHIFT  = 6
) (
    input  mode_e            mode_q,
    input  logic [11:0]      x,
    input  logic [9:0]       y,
    input  logic [2:0]       bar,
    output logic [DAC_W-1:0] level
);

    localparam int AW = DAC_W + 2;
    localparam logic [AW-1:0] BLK = AW'(BLANK_LVL);
    localparam logic [AW-1:0] WHT = AW'(WHITE_LVL);

    logic [11:0]   xs;
    logic [AW-1:0] sum;
    logic          sat;
    logic          chk_on;

    always_comb begin
        xs     = x >> RAMP_SHIFT;
        sum    = BLK;
        sat    = 1'b0;
        chk_on = ((x >> CHK_SHIFT) & 12'd1)
                 != ((12'(y) >> CHK_SHIFT) & 12'd1);
        unique case (mode_q)
            MODE_BLACK: sum = BLK;
            MODE_BARS:  sum = BLK + AW'(bar) * AW'(BAR_STEP);
            MODE_RAMP: begin
                // a shifted x wider than the adder saturates directly
                sat = xs > 12'(WHITE_LVL);
                sum = BLK + AW'(xs);
            end
            MODE_CHECK: sum = chk_on ? WHT : BLK;
            default:    sum = BLK;
        endcase
        level = (sat || sum > WHT) ? DAC_W'(WHITE_LVL) : sum[DAC_W-1:0];
    end

endmodule

// File: rtl/pal_video_gen.sv
// PAL-style composite video timing, test patterns and frame-locked LED.
// Counters feed a single output register stage driving the video DAC.
module pal_video_gen
    import pal_pkg::*;
#(
    parameter int DAC_W      = 8,
    parameter int H_TOTAL    = 3200,
    parameter int H_SYNC     = 235,
    parameter int H_BACK     = 285,
    parameter int H_ACTIVE   = 2600,
    parameter int V_TOTAL    = 312,
    parameter int V_SYNC     = 3,
    parameter int V_BLANK    = 20,
    parameter int BLANK_LVL  = DEF_BLANK_LVL,
    parameter int WHITE_LVL  = DEF_WHITE_LVL,
    parameter int BAR_W      = 325,
    parameter int BAR_STEP   = 25,
    parameter int RAMP_SHIFT = 4,
    parameter int CHK_SHIFT  = 6,
    parameter int HB_FIELDS  = 25
) (
    input  logic             clk50,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    output logic [DAC_W-1:0] dac,
    output logic             sync_n,
    output logic             blank,
    output logic [11:0]      x,
    output logic [9:0]       y,
    output logic             frame_start,
    output logic             led
);

    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] H_SYNC_E = 12'(H_SYNC);
    localparam logic [11:0] ACT_PRE  = 12'(H_SYNC + H_BACK - 1);
    localparam logic [11:0] ACT_BEG  = 12'(H_SYNC + H_BACK);
    localparam logic [11:0] ACT_END  = 12'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [11:0] BROAD_E  = 12'(H_TOTAL - H_SYNC);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_SYNC_E = 10'(V_SYNC);
    localparam logic [9:0]  V_ACT    = 10'(V_SYNC + V_BLANK);
    localparam logic [11:0] BAR_LAST = 12'(BAR_W - 1);
    localparam logic [15:0] HB_LAST  = 16'(HB_FIELDS - 1);

    logic [11:0]      hc;
    logic [9:0]       vc;
    mode_e            mode_q;
    logic [2:0]       bar;
    logic [11:0]      bar_cnt;
    logic [15:0]      fld_cnt;

    logic             h_wrap;
    logic             v_wrap;
    logic             at_origin;
    logic             in_sync;
    logic             act;
    logic [11:0]      x_c;
    logic [9:0]       y_c;
    logic [DAC_W-1:0] level;

    always_comb begin
        h_wrap    = hc == H_LAST;
        v_wrap    = vc == V_LAST;
        at_origin = (hc == 12'd0) && (vc == 10'd0);
        // broad-sync lines hold sync for all but the last H_SYNC clocks
        in_sync   = (vc < V_SYNC_E) ? (hc < BROAD_E) : (hc < H_SYNC_E);
        act       = (vc >= V_ACT) && (hc >= ACT_BEG) && (hc < ACT_END);
        x_c       = hc - ACT_BEG;
        y_c       = vc - V_ACT;
    end

    pal_pattern #(
        .DAC_W     (DAC_W),
        .BLANK_LVL (BLANK_LVL),
        .WHITE_LVL (WHITE_LVL),
        .BAR_STEP  (BAR_STEP),
        .RAMP_SHIFT(RAMP_SHIFT),
        .CHK_SHIFT (CHK_SHIFT)
    ) u_pattern (
        .mode_q(mode_q),
        .x     (x_c),
        .y     (y_c),
        .bar   (bar),
        .level (level)
    );

    always_ff @(posedge clk50) begin
        if (!rst_n) begin
            hc          <= '0;
            vc          <= '0;
            mode_q      <= MODE_BLACK;
            bar         <= '0;
            bar_cnt     <= '0;
            fld_cnt     <= '0;
            dac         <= DAC_W'(BLANK_LVL);
            sync_n      <= 1'b1;
            blank       <= 1'b1;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
            led         <= 1'b0;
        end else begin
            hc <= h_wrap ? 12'd0 : hc + 12'd1;
            if (h_wrap) begin
                vc <= v_wrap ? 10'd0 : vc + 10'd1;
            end

            if (at_origin) begin
                mode_q <= mode_e'(mode);
            end

            // bar index tracks the pixel being evaluated this cycle
            if (hc == ACT_PRE) begin
                bar     <= '0;
                bar_cnt <= '0;
            end else if (act) begin
                if (bar_cnt == BAR_LAST) begin
                    bar_cnt <= '0;
                    if (bar != 3'(BAR_MAX)) begin
                        bar <= bar + 3'd1;
                    end
                end else begin
                    bar_cnt <= bar_cnt + 12'd1;
                end
            end

            frame_start <= at_origin;

            unique case (1'b1)
                in_sync: begin
                    dac    <= DAC_W'(SYNC_LVL);
                    sync_n <= 1'b0;
                    blank  <= 1'b1;
                end
                act: begin
                    dac    <= level;
                    sync_n <= 1'b1;
                    blank  <= 1'b0;
                    x      <= x_c;
                    y      <= y_c;
                end
                default: begin
                    dac    <= DAC_W'(BLANK_LVL);
                    sync_n <= 1'b1;
                    blank  <= 1'b1;
                end
            endcase

            if (h_wrap && v_wrap) begin
                if (fld_cnt == HB_LAST) begin
                    fld_cnt <= '0;
                    led     <= ~led;
                end else begin
                    fld_cnt <= fld_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: doc/pal_video_gen.md
Name: pal_video_gen

Overview:
- Parametrised PAL-style composite video generator driving the 8-bit DAC on vga_r, plus a frame-locked LED heartbeat.
- Successor to the free-running LED blinker in the paltest top, which currently ties vga_r to zero.
- Produces line and field timing, sync/blank levels and selectable test patterns.
- Instantiated in the paltest top; dac drives vga_r, led drives led1/led2.

Parameters:
- DAC_W, 8, DAC output width.
- H_TOTAL, 3200, clocks per line (64 us at 50 MHz).
- H_SYNC, 235, hsync width in clocks.
- H_BACK, 285, back porch width in clocks.
- H_ACTIVE, 2600, active width in clocks; front porch = H_TOTAL-H_SYNC-H_BACK-H_ACTIVE, which must be >= 1.
- V_TOTAL, 312, lines per field (progressive).
- V_SYNC, 3, broad-sync lines.
- V_BLANK, 20, blank lines after the broad-sync lines.
- BLANK_LVL, 77, blanking/black DAC code.
- WHITE_LVL, 255, white DAC code.
- BAR_W, 325, clocks per grey bar.
- BAR_STEP, 25, DAC increment per bar.
- RAMP_SHIFT, 4, right shift of x used for the ramp pattern.
- CHK_SHIFT, 6, bit of x and y used for the checkerboard.
- HB_FIELDS, 25, fields per LED toggle.

Ports:
- clk50  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- mode  in  2  pattern select: 0 black, 1 bars, 2 ramp, 3 checker
- dac  out  DAC_W  composite level
- sync_n  out  1  low while dac is at sync level
- blank  out  1  high outside the active region
- x  out  12  active pixel column
- y  out  10  active line
- frame_start  out  1  one-cycle pulse
- led  out  1  heartbeat

Behaviour:
- Reset: rst_n is sampled on the rising edge of clk50 and is synchronous, active-low. While asserted:
  - hc=0, vc=0, mode_q=0, bar counter=0, field counter=0.
  - dac=BLANK_LVL, sync_n=1, blank=1, x=0, y=0, frame_start=0, led=0.
  - Reset mid-line or mid-field abandons the frame. The first cycle after release is hc=0, vc=0.
- Counters:
  - hc counts 0..H_TOTAL-1 and wraps to 0.
  - vc increments when hc wraps and wraps to 0 after V_TOTAL-1.
- Horizontal regions:
  - sync: hc < H_SYNC.
  - back porch: H_SYNC <= hc < H_SYNC+H_BACK.
  - active: next H_ACTIVE clocks.
  - front porch: remainder of the line.
- Vertical regions:
  - vc < V_SYNC: broad sync. Sync is asserted for hc < H_TOTAL-H_SYNC and released (BLANK_LVL) for the last H_SYNC clocks. No active video.
  - V_SYNC <= vc < V_SYNC+V_BLANK: normal hsync, blanked, no active video.
  - Otherwise: active lines with y = vc-V_SYNC-V_BLANK.
- Active region: x = hc-H_SYNC-H_BACK.
- Output pipeline:
  - One register stage. dac, sync_n, blank, x and y at cycle n+1 reflect hc/vc at cycle n.
  - Sync: dac=0, sync_n=0, blank=1.
  - Blank: dac=BLANK_LVL, sync_n=1, blank=1.
  - Outside the active region, x and y hold their last values.
- Patterns (active region only; arithmetic at DAC_W+2 bits, result clamped to WHITE_LVL):
  - mode 0: BLANK_LVL.
  - mode 1: BLANK_LVL + bar*BAR_STEP.
    - bar resets to 0 at active start and increments every BAR_W active clocks.
    - bar saturates at 7.
    - No divider is used.
  - mode 2: min(WHITE_LVL, BLANK_LVL + (x>>RAMP_SHIFT)).
  - mode 3: WHITE_LVL if x[CHK_SHIFT]^y[CHK_SHIFT] is 1, else BLANK_LVL.
- Mode capture: mode is captured into mode_q only on the cycle where hc=0 and vc=0. A mid-field mode change takes effect at the next field.
- frame_start: high for exactly one cycle, aligned with the output for hc=0, vc=0, i.e. the cycle after the counters reach 0.
- Heartbeat:
  - The field counter increments on each field wrap.
  - At HB_FIELDS-1 it resets to 0 and led toggles.
  - Defaults give 0.5 s toggle, 1 Hz blink.

Decomposition:
- Shared package pal_pkg holds:
  - mode encoding constants MODE_BLACK, MODE_BARS, MODE_RAMP, MODE_CHECK;
  - sync level constant SYNC_LVL=0;
  - default BLANK_LVL and WHITE_LVL.
- One sub-module, pal_pattern: combinational pattern function of (mode_q, x, y, bar) to level, including the clamp.
- The timing counters, bar counter, output register and heartbeat stay in pal_video_gen.

Test Plan:
- Default parameters, rst_n released: sync_n low for exactly 235 clocks per line; falling edges of sync_n 3200 clocks apart; frame_start period 998400 clocks.
- Small parameters (H_TOTAL=40, H_SYNC=4, H_BACK=4, H_ACTIVE=24, V_TOTAL=8, V_SYNC=1, V_BLANK=1), mode=1, BAR_W=3:
  - line 0: sync_n low for 36 clocks, then high 4;
  - active line: dac sequence 77×3, 102×3, 127×3 … up to 252×3.
- mode=2 with RAMP_SHIFT=0 and WHITE_LVL=90 (small parameters): dac ramps 77,78…90 and then holds 90 to the end of active.
- mode switched 0→3 mid-field: dac stays 77 in active until the next frame_start, then checkerboard (77/255) from the first active line.
- rst_n pulsed low 1 cycle mid-active-line:
  - next cycle dac=77, sync_n=1, led=0;
  - the following cycle shows hc=0 output (sync_n=0, dac=0).
- HB_FIELDS=2 (small parameters): led toggles every 2 frame_start pulses; first toggle after the second field wrap.
